ahb_decode_stage_param: RTL and testbench

//  Parametrised bus-matrix decoder stage: one AHB input port fanned out to N_PORTS output stages plus built-in default slave.

---
 rtl/ahb_dec_pkg.sv | 54 +++++
 rtl/ahb_dec_default_slave.sv | 54 +++++
 rtl/ahb_decode_stage_param.sv | 126 ++++++++++++
 tb/tb_ahb_decode_stage_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_dec_pkg.sv
// ============================================================================
// Module : ahb_dec_pkg
// Brief  : Shared AHB encodings, decode helpers and default-slave state type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_dec_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int DEC_LSB = 10;

  typedef enum logic [1:0] {
    DFT_IDLE = 2'd0,
    DFT_ERR1 = 2'd1,
    DFT_ERR2 = 2'd2
  } dft_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Range test via borrow bits so a zero base never yields a constant compare.
  function automatic logic in_range(input logic [21:0] a, input logic [21:0] lo,
                                    input logic [21:0] hi);
    logic [22:0] d_lo;
    logic [22:0] d_hi;
    d_lo = {1'b0, a} - {1'b0, lo};
    d_hi = {1'b0, hi} - {1'b0, a};
    return !d_lo[22] && !d_hi[22];
  endfunction

  function automatic logic trans_valid(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_dec_default_slave.sv
// ============================================================================
// Module : ahb_dec_default_slave
// Brief  : Built-in default slave, two-cycle ERROR for any valid transfer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_dec_default_slave
  import ahb_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       ready_in,
  input  logic [1:0] trans,
  output logic       ready,
  output logic [1:0] resp
);

  dft_state_t state;
  dft_state_t state_nxt;
  logic       start;

  assign start = sel & ready_in & trans_valid(trans);

  always_ff @(posedge clk) begin
    if (rst) state <= DFT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    resp      = HRESP_OKAY;
    case (state)
      DFT_IDLE: begin
        if (start) state_nxt = DFT_ERR1;
      end
      DFT_ERR1: begin
        ready     = 1'b0;
        resp      = HRESP_ERROR;
        state_nxt = DFT_ERR2;
      end
      DFT_ERR2: begin
        resp      = HRESP_ERROR;
        state_nxt = start ? DFT_ERR1 : DFT_IDLE;
      end
      default: state_nxt = DFT_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ahb_decode_stage_param.sv
// ============================================================================
// Module : ahb_decode_stage_param
// Brief  : AHB decoder stage, N_PORTS outputs plus default slave; optional
//          unmapped-access capture under AHB_DEC_ERR_CAPTURE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_decode_stage_param
  import ahb_dec_pkg::*;
#(
  parameter int                   N_PORTS    = 5,
  parameter int                   DATA_W     = 32,
  parameter logic [N_PORTS*22-1:0] PORT_BASE  = {22'h100044, 22'h100040, 22'h100000,
                                                 22'h080000, 22'h000000},
  parameter logic [N_PORTS*22-1:0] PORT_LIMIT = {22'h100057, 22'h100043, 22'h100017,
                                                 22'h0803ff, 22'h0003ff}
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HREADYS,
  input  logic                      sel_dec,
  input  logic [21:0]               decode_addr_dec,
  input  logic [1:0]                trans_dec,
  input  logic [N_PORTS-1:0]        active_dec_i,
  input  logic [N_PORTS-1:0]        readyout_dec,
  input  logic [2*N_PORTS-1:0]      resp_dec,
  input  logic [DATA_W*N_PORTS-1:0] rdata_dec,
  output logic [N_PORTS-1:0]        sel_dec_o,
  output logic                      active_dec,
  output logic                      HREADYOUTS,
  output logic [1:0]                HRESPS,
  output logic [DATA_W-1:0]         HRDATAS,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [21:0]               err_addr
);

  localparam int               IDX_W   = clog2(N_PORTS + 1);
  localparam logic [IDX_W-1:0] DFT_IDX = IDX_W'(N_PORTS);

  logic [IDX_W-1:0] dec_port;
  logic [IDX_W-1:0] addr_port;
  logic [IDX_W-1:0] data_port;
  logic             dft_sel;
  logic             dft_ready;
  logic [1:0]       dft_resp;

  // Descending scan so the lowest matching port wins on overlap.
  always_comb begin
    dec_port = DFT_IDX;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (in_range(decode_addr_dec, PORT_BASE[p*22 +: 22], PORT_LIMIT[p*22 +: 22]))
        dec_port = IDX_W'(p);
    end
    addr_port = (trans_dec == HTRANS_IDLE) ? data_port : dec_port;
  end

  always_comb begin
    sel_dec_o  = '0;
    active_dec = 1'b1;
    for (int p = 0; p < N_PORTS; p++) begin
      if (addr_port == IDX_W'(p)) begin
        sel_dec_o[p] = sel_dec;
        active_dec   = active_dec_i[p];
      end
    end
  end

  assign dft_sel = sel_dec & (addr_port == DFT_IDX);

  always_ff @(posedge HCLK) begin
    if (HRESET)       data_port <= DFT_IDX;
    else if (HREADYS) data_port <= addr_port;
  end

  ahb_dec_default_slave u_dft (
    .clk      (HCLK),
    .rst      (HRESET),
    .sel      (dft_sel),
    .ready_in (HREADYS),
    .trans    (trans_dec),
    .ready    (dft_ready),
    .resp     (dft_resp)
  );

  always_comb begin
    HREADYOUTS = dft_ready;
    HRESPS     = dft_resp;
    HRDATAS    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (data_port == IDX_W'(p)) begin
        HREADYOUTS = readyout_dec[p];
        HRESPS     = resp_dec[2*p +: 2];
        HRDATAS    = rdata_dec[DATA_W*p +: DATA_W];
      end
    end
  end

`ifdef AHB_DEC_ERR_CAPTURE_EN
  logic capture;

  // A simultaneous clear re-arms capture so the new address is recorded.
  assign capture = dft_sel & HREADYS & trans_valid(trans_dec) & (~err_valid | err_clr);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (capture) begin
      err_valid <= 1'b1;
      err_addr  <= decode_addr_dec;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_valid      = 1'b0;
  assign err_addr       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_decode_stage_param.sv
// ============================================================================
// Module : tb_ahb_decode_stage_param
// Brief  : Directed scoreboard bench for ahb_decode_stage_param.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_decode_stage_param;

  localparam int N_PORTS = 5;
  localparam int DATA_W  = 32;
`ifdef AHB_DEC_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;

  logic                      HCLK;
  logic                      HRESET;
  logic                      HREADYS;
  logic                      sel_dec;
  logic [21:0]               decode_addr_dec;
  logic [1:0]                trans_dec;
  logic [N_PORTS-1:0]        active_dec_i;
  logic [N_PORTS-1:0]        readyout_dec;
  logic [2*N_PORTS-1:0]      resp_dec;
  logic [DATA_W*N_PORTS-1:0] rdata_dec;
  logic [N_PORTS-1:0]        sel_dec_o;
  logic                      active_dec;
  logic                      HREADYOUTS;
  logic [1:0]                HRESPS;
  logic [DATA_W-1:0]         HRDATAS;
  logic                      err_clr;
  logic                      err_valid;
  logic [21:0]               err_addr;

  ahb_decode_stage_param dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HREADYS         (HREADYS),
    .sel_dec         (sel_dec),
    .decode_addr_dec (decode_addr_dec),
    .trans_dec       (trans_dec),
    .active_dec_i    (active_dec_i),
    .readyout_dec    (readyout_dec),
    .resp_dec        (resp_dec),
    .rdata_dec       (rdata_dec),
    .sel_dec_o       (sel_dec_o),
    .active_dec      (active_dec),
    .HREADYOUTS      (HREADYOUTS),
    .HRESPS          (HRESPS),
    .HRDATAS         (HRDATAS),
    .err_clr         (err_clr),
    .err_valid       (err_valid),
    .err_addr        (err_addr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        ready;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } dp_t;

  dp_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  function automatic logic [31:0] pdata(input int p);
    return 32'hD000_0000 | (32'(p) * 32'h0000_1111);
  endfunction

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [21:0] a, input logic [1:0] t,
                       input logic hr);
    sel_dec         = s;
    decode_addr_dec = a;
    trans_dec       = t;
    HREADYS         = hr;
  endtask

  task automatic push(input logic r, input logic [1:0] rs, input logic [31:0] d);
    dp_t e;
    e.ready = r;
    e.resp  = rs;
    e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic comb(input logic [4:0] s_exp, input logic act_exp, input string tag);
    #1;
    chk(64'(sel_dec_o), 64'(s_exp), {tag, ".sel"});
    chk(64'(active_dec), 64'(act_exp), {tag, ".active"});
  endtask

  task automatic tick(input string tag);
    dp_t e;
    @(posedge HCLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(64'(HREADYOUTS), 64'(e.ready), {tag, ".ready"});
      chk(64'(HRESPS), 64'(e.resp), {tag, ".resp"});
      chk(64'(HRDATAS), 64'(e.rdata), {tag, ".rdata"});
    end
  endtask

  task automatic check_err(input logic v, input logic [21:0] a, input string tag);
    chk(64'(err_valid), 64'(v), {tag, ".err_valid"});
    chk(64'(err_addr), 64'(a), {tag, ".err_addr"});
  endtask

  initial begin
    HRESET       = 1'b1;
    err_clr      = 1'b0;
    active_dec_i = 5'b01010;
    readyout_dec = '1;
    resp_dec     = '0;
    for (int p = 0; p < N_PORTS; p++) rdata_dec[DATA_W*p +: DATA_W] = pdata(p);
    drive(1'b0, 22'h0, T_IDLE, 1'b1);

    // Reset state
    push(1'b1, OKAY, 32'h0);
    @(posedge HCLK);
    tick("reset");
    comb(5'b00000, 1'b1, "reset");
    check_err(1'b0, 22'h0, "reset");
    HRESET = 1'b0;

    // Mapped NONSEQ to port 1
    drive(1'b1, 22'h080010, T_NSEQ, 1'b1);
    comb(5'b00010, 1'b1, "p1_addr");
    push(1'b1, OKAY, pdata(1));
    tick("p1_data");

    // Unmapped NONSEQ -> two-cycle ERROR from default slave
    drive(1'b1, 22'h200000, T_NSEQ, 1'b1);
    comb(5'b00000, 1'b1, "dft_addr");
    push(1'b0, ERROR, 32'h0);
    tick("dft_err1");
    drive(1'b0, 22'h0, T_IDLE, 1'b0);
    push(1'b1, ERROR, 32'h0);
    tick("dft_err2");
    drive(1'b0, 22'h0, T_IDLE, 1'b1);
    push(1'b1, OKAY, 32'h0);
    tick("dft_idle");

    // Port 2 then IDLE to port-0 address keeps select on port 2
    drive(1'b1, 22'h100000, T_NSEQ, 1'b1);
    comb(5'b00100, 1'b0, "p2_addr");
    push(1'b1, OKAY, pdata(2));
    tick("p2_data");
    drive(1'b1, 22'h000000, T_IDLE, 1'b1);
    comb(5'b00100, 1'b0, "idle_hold");
    push(1'b1, OKAY, pdata(2));
    tick("idle_hold_data");

    // Port 3 with three wait states; pipelined port-4 address held
    drive(1'b1, 22'h100040, T_NSEQ, 1'b1);
    comb(5'b01000, 1'b1, "p3_addr");
    readyout_dec = 5'b10111;
    push(1'b0, OKAY, pdata(3));
    tick("p3_wait1");
    drive(1'b1, 22'h100044, T_NSEQ, 1'b0);
    comb(5'b10000, 1'b0, "p4_addr");
    push(1'b0, OKAY, pdata(3));
    tick("p3_wait2");
    push(1'b0, OKAY, pdata(3));
    tick("p3_wait3");
    readyout_dec = '1;
    #1;
    chk(64'(HREADYOUTS), 64'(1'b1), "p3_done.ready");
    chk(64'(HRDATAS), 64'(pdata(3)), "p3_done.rdata");

    // Port 4 accepted; its HRESP routed back
    resp_dec[9:8] = ERROR;
    drive(1'b1, 22'h100044, T_NSEQ, 1'b1);
    push(1'b1, ERROR, pdata(4));
    tick("p4_data");
    resp_dec = '0;

    // Error capture: first unmapped address is sticky
    drive(1'b1, 22'h3FFFFF, T_NSEQ, 1'b1);
    push(1'b0, ERROR, 32'h0);
    tick("cap1_err1");
    check_err(CAP, CAP ? 22'h3FFFFF : 22'h0, "cap1");
    drive(1'b0, 22'h0, T_IDLE, 1'b0);
    push(1'b1, ERROR, 32'h0);
    tick("cap1_err2");
    drive(1'b1, 22'h200000, T_NSEQ, 1'b1);
    push(1'b0, ERROR, 32'h0);
    tick("cap2_err1");
    check_err(CAP, CAP ? 22'h3FFFFF : 22'h0, "cap2_sticky");
    drive(1'b0, 22'h0, T_IDLE, 1'b0);
    push(1'b1, ERROR, 32'h0);
    tick("cap2_err2");

    // Clear and new capture in the same cycle: capture wins
    err_clr = 1'b1;
    drive(1'b1, 22'h2AAAAA, T_NSEQ, 1'b1);
    push(1'b0, ERROR, 32'h0);
    tick("cap3_err1");
    err_clr = 1'b0;
    check_err(CAP, CAP ? 22'h2AAAAA : 22'h0, "cap3_clr");

    // Reset while in ERR1 abandons the ERROR response
    HRESET = 1'b1;
    drive(1'b0, 22'h0, T_IDLE, 1'b0);
    push(1'b1, OKAY, 32'h0);
    tick("rst_err1");
    check_err(1'b0, 22'h0, "rst_err1");
    HRESET = 1'b0;

    // BUSY to unmapped address is not an error
    drive(1'b1, 22'h200000, T_BUSY, 1'b1);
    push(1'b1, OKAY, 32'h0);
    tick("busy_dft");
    check_err(1'b0, 22'h0, "busy_dft");

    chk(64'(sb.size()), 64'd0, "scoreboard_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
